// File: rtl/sfp_led_status.sv
`timescale 1ns/1ps
// SFP front-panel LED driver: link LED (solid/slow blink) and activity LED (blink with enforced off-gap).
// Optional error fast-blink override on the link LED is built only when SFP_LED_ERR_EN is defined.
module sfp_led_status #(
  parameter int SFP_COUNT      = 1,
  parameter int CLK_HZ         = 100_000_000,
  parameter int ACT_ON_MS      = 50,
  parameter int ACT_OFF_MS     = 50,
  parameter int SLOW_HALF_MS   = 500,
  parameter int FAST_HALF_MS   = 100,
  parameter int ERR_HOLD_MS    = 1000,
  parameter int LED_ACTIVE_LOW = 0
) (
  input  logic                 sysclk_100m,
  input  logic                 sys_reset,
  input  logic [SFP_COUNT-1:0] link_up,
  input  logic [SFP_COUNT-1:0] rx_act,
  input  logic [SFP_COUNT-1:0] tx_act,
  input  logic [SFP_COUNT-1:0] err_pulse,
  output logic [1:0]           sleds
);

  function automatic int cnt_w(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

  localparam int DIV     = CLK_HZ / 1000;
  localparam int PRE_W   = cnt_w(DIV);
  localparam int SLOW_W  = cnt_w(SLOW_HALF_MS);
  localparam int FAST_W  = cnt_w(FAST_HALF_MS);
  localparam int ACT_MAX = (ACT_ON_MS > ACT_OFF_MS) ? ACT_ON_MS : ACT_OFF_MS;
  localparam int ACT_W   = cnt_w(ACT_MAX);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_HALF_MS - 1);
  localparam logic [FAST_W-1:0] FAST_LAST = FAST_W'(FAST_HALF_MS - 1);
  localparam logic [ACT_W-1:0]  ON_LAST   = ACT_W'(ACT_ON_MS - 1);
  localparam logic [ACT_W-1:0]  OFF_LAST  = ACT_W'(ACT_OFF_MS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  logic [SFP_COUNT-1:0] r_link_s1, r_link_s2;
  logic [PRE_W-1:0]     r_presc;
  logic [SLOW_W-1:0]    r_slow_cnt;
  logic [FAST_W-1:0]    r_fast_cnt;
  logic                 r_slow_phase, r_fast_phase;
  state_t               r_state, w_state_nxt;
  logic [ACT_W-1:0]     r_act_cnt, w_act_cnt_nxt;
  logic                 r_pending, w_pending_nxt;
  logic                 w_ms_tick, w_act, w_link_base, w_link_led;
  logic [1:0]           w_led;

  // link_up is asynchronous; only the second flop feeds the LED logic
  always_ff @(posedge sysclk_100m or posedge sys_reset) begin
    if (sys_reset) begin
      r_link_s1 <= '0;
      r_link_s2 <= '0;
    end else begin
      r_link_s1 <= link_up;
      r_link_s2 <= r_link_s1;
    end
  end

  assign w_ms_tick = (r_presc == PRE_LAST);

  always_ff @(posedge sysclk_100m or posedge sys_reset) begin
    if (sys_reset) begin
      r_presc      <= '0;
      r_slow_cnt   <= '0;
      r_fast_cnt   <= '0;
      r_slow_phase <= 1'b0;
      r_fast_phase <= 1'b0;
    end else begin
      r_presc <= w_ms_tick ? '0 : r_presc + 1'b1;
      if (w_ms_tick) begin
        if (r_slow_cnt == SLOW_LAST) begin
          r_slow_cnt   <= '0;
          r_slow_phase <= ~r_slow_phase;
        end else begin
          r_slow_cnt <= r_slow_cnt + 1'b1;
        end
        if (r_fast_cnt == FAST_LAST) begin
          r_fast_cnt   <= '0;
          r_fast_phase <= ~r_fast_phase;
        end else begin
          r_fast_cnt <= r_fast_cnt + 1'b1;
        end
      end
    end
  end

  assign w_link_base = (&r_link_s2) ? 1'b1 : ((|r_link_s2) ? r_slow_phase : 1'b0);

`ifdef SFP_LED_ERR_EN
  localparam int ERR_W = cnt_w(ERR_HOLD_MS + 1);
  localparam logic [ERR_W-1:0] ERR_LOAD = ERR_W'(ERR_HOLD_MS);

  logic [ERR_W-1:0] r_err_hold;

  // a new error pulse reloads the hold even when a tick lands in the same cycle
  always_ff @(posedge sysclk_100m or posedge sys_reset) begin
    if (sys_reset) begin
      r_err_hold <= '0;
    end else if (|err_pulse) begin
      r_err_hold <= ERR_LOAD;
    end else if (w_ms_tick && (r_err_hold != '0)) begin
      r_err_hold <= r_err_hold - 1'b1;
    end
  end

  assign w_link_led = (r_err_hold != '0) ? r_fast_phase : w_link_base;
`else
  logic w_unused_err;
  assign w_unused_err = ^{err_pulse, r_fast_phase};
  assign w_link_led   = w_link_base;
`endif

  assign w_act = |(rx_act | tx_act);

  always_ff @(posedge sysclk_100m or posedge sys_reset) begin
    if (sys_reset) begin
      r_state   <= S_IDLE;
      r_act_cnt <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_act_cnt <= w_act_cnt_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // Events during ON/GAP are remembered so busy traffic blinks instead of lighting solid
  always_comb begin
    w_state_nxt   = r_state;
    w_act_cnt_nxt = r_act_cnt;
    w_pending_nxt = r_pending;
    case (r_state)
      S_IDLE: begin
        if (w_act) begin
          w_state_nxt   = S_ON;
          w_act_cnt_nxt = '0;
          w_pending_nxt = 1'b0;
        end
      end
      S_ON: begin
        if (w_act) w_pending_nxt = 1'b1;
        if (w_ms_tick) begin
          if (r_act_cnt == ON_LAST) begin
            w_state_nxt   = S_GAP;
            w_act_cnt_nxt = '0;
          end else begin
            w_act_cnt_nxt = r_act_cnt + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (w_act) w_pending_nxt = 1'b1;
        if (w_ms_tick) begin
          if (r_act_cnt == OFF_LAST) begin
            w_act_cnt_nxt = '0;
            if (r_pending || w_act) begin
              w_state_nxt   = S_ON;
              w_pending_nxt = 1'b0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_act_cnt_nxt = r_act_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_act_cnt_nxt = '0;
        w_pending_nxt = 1'b0;
      end
    endcase
  end

  assign w_led = {(r_state == S_ON), w_link_led};
  assign sleds = (LED_ACTIVE_LOW != 0) ? ~w_led : w_led;

endmodule

// File: tb/tb_sfp_led_status.sv
`timescale 1ns/1ps
// Directed bench for sfp_led_status at 10 cycles/ms; a second instance checks the active-low polarity.
module tb_sfp_led_status;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] link_up = '0, rx_act = '0, tx_act = '0, err_pulse = '0;
  logic [1:0] sleds, sleds_al;
  int         cyc = 0;
  int         nvec = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  // cycles since reset release; the DUT prescaler restarts from the same point
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  sfp_led_status #(
    .SFP_COUNT(2), .CLK_HZ(10_000), .ACT_ON_MS(2), .ACT_OFF_MS(2),
    .SLOW_HALF_MS(5), .FAST_HALF_MS(1), .ERR_HOLD_MS(4), .LED_ACTIVE_LOW(0)
  ) u_dut (
    .sysclk_100m(clk), .sys_reset(rst), .link_up(link_up), .rx_act(rx_act),
    .tx_act(tx_act), .err_pulse(err_pulse), .sleds(sleds)
  );

  sfp_led_status #(
    .SFP_COUNT(2), .CLK_HZ(10_000), .ACT_ON_MS(2), .ACT_OFF_MS(2),
    .SLOW_HALF_MS(5), .FAST_HALF_MS(1), .ERR_HOLD_MS(4), .LED_ACTIVE_LOW(1)
  ) u_dut_al (
    .sysclk_100m(clk), .sys_reset(rst), .link_up(link_up), .rx_act(rx_act),
    .tx_act(tx_act), .err_pulse(err_pulse), .sleds(sleds_al)
  );

  typedef struct {
    logic [1:0] link;
    int         hold;
    bit         use_slow;
    logic [1:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [1:0] exp);
    nvec++;
    if (sleds !== exp || sleds_al !== ~exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d sleds=%b sleds_al=%b required=%b/%b", name, cyc, sleds, sleds_al, exp, ~exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // stop at the negedge just before a ms-tick edge
  task automatic align9();
    for (int k = 0; k < 12; k++) begin
      if (cyc % 10 == 9) break;
      @(negedge clk);
    end
  endtask

  task automatic act_seq(input string nm, input bit late);
    logic e;
    align9();
    rx_act = 2'b10;
    step(1);
    rx_act = 2'b00;
    for (int m = 0; m < 120; m++) begin
      e = (m < 20) || (late && m >= 40 && m < 60);
      chk(nm, {e, 1'b0});
      if (late && m == 39) rx_act = 2'b01;
      if (m == 40) rx_act = 2'b00;
      step(1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  initial begin
    logic [1:0] exp;
    logic       e0;

    tbl[0] = '{2'b11, 3,  1'b0, 2'b01, "all_up"};
    tbl[1] = '{2'b00, 3,  1'b0, 2'b00, "all_down"};
    tbl[2] = '{2'b01, 3,  1'b1, 2'b00, "partial_01"};
    tbl[3] = '{2'b10, 60, 1'b1, 2'b00, "partial_10"};
    tbl[4] = '{2'b11, 3,  1'b0, 2'b01, "up_again"};
    tbl[5] = '{2'b00, 3,  1'b0, 2'b00, "down_again"};

    // reset dominates inputs
    rst = 1'b1;
    step(3);
    chk("reset_plain", 2'b00);
    link_up = 2'b11;
    rx_act  = 2'b11;
    step(3);
    chk("reset_with_inputs", 2'b00);
    link_up = 2'b00;
    rx_act  = 2'b00;
    rst     = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      step(1);
      chk("idle_after_reset", 2'b00);
    end

    for (int i = 0; i < 6; i++) begin
      link_up = tbl[i].link;
      step(tbl[i].hold);
      exp = tbl[i].exp;
      if (tbl[i].use_slow) exp[0] = ((cyc / 50) % 2 == 1);
      chk(tbl[i].name, exp);
    end

    link_up = 2'b01;
    step(3);
    for (int i = 0; i < 120; i++) begin
      exp    = 2'b00;
      exp[0] = ((cyc / 50) % 2 == 1);
      chk("slow_blink", exp);
      step(1);
    end
    link_up = 2'b00;
    step(3);
    chk("link_off", 2'b00);

    act_seq("rx_single", 1'b0);
    act_seq("rx_at_gap_end", 1'b1);

    align9();
    for (int m = -1; m < 300; m++) begin
      if (m >= 0) chk("tx_stream", {(m < 240) && ((m % 40) < 20), 1'b0});
      tx_act = (m < 199) ? 2'b01 : 2'b00;
      step(1);
    end

    link_up = 2'b11;
    step(3);
    chk("link_up_pre_err", 2'b01);
    align9();
    err_pulse = 2'b01;
    step(1);
    err_pulse = 2'b00;
    for (int m = 0; m < 60; m++) begin
`ifdef SFP_LED_ERR_EN
      e0 = (m < 40) ? ((cyc / 10) % 2 == 1) : 1'b1;
`else
      e0 = 1'b1;
`endif
      chk("err_blink", {1'b0, e0});
      step(1);
    end

    link_up = 2'b00;
    step(3);
    align9();
    rx_act = 2'b01;
    step(1);
    rx_act = 2'b00;
    step(5);
    chk("on_before_reset", 2'b10);
    #2 rst = 1'b1;
    #1 chk("reset_async_abort", 2'b00);
    step(3);
    chk("reset_held_mid_on", 2'b00);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      chk("no_blink_after_reset", 2'b00);
    end
    align9();
    rx_act = 2'b10;
    step(1);
    rx_act = 2'b00;
    chk("fresh_event_on", 2'b10);
    step(19);
    chk("fresh_event_last_on", 2'b10);
    step(1);
    chk("fresh_event_off", 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
